// File: rtl/char_stream_pkg.sv
// Shared constants, FSM state type and byte classification for the character
// stream framer.
package char_stream_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORD,
        S_DROP
    } framer_state_t;

    // Printable ASCII is 0x20..0x7E inclusive.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SP) && (c < ASCII_DEL);
    endfunction

    function automatic logic is_terminator(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy counter. Full/empty are derived
// from the level so that in_ready upstream never depends combinationally on
// in_valid. The read port is a combinational look at the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             push;
    logic             pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents are don't-care until the level says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of 2); level tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/char_stream_framer.sv
// Input stage of the password checker: buffers upstream ASCII bytes in a FIFO,
// drains one per cycle, frames words on CR/LF, drops non-printables and caps each
// word at MAX_LEN forwarded characters.
// Optional feature: define CASE_FOLD_EN to forward 'A'..'Z' as lowercase.
module char_stream_framer
    import char_stream_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MAX_LEN = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     hold,
    output logic                     en,
    output logic [7:0]               data_out,
    output logic                     word_end,
    output logic [5:0]               word_len,
    output logic                     word_ovf,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam logic [5:0] MaxLen = 6'(MAX_LEN);

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    head_byte;
    logic          pop;
    logic [7:0]    fwd_byte;
    framer_state_t state;
    logic [5:0]    count;

    assign in_ready = !fifo_full;
    assign pop      = !fifo_empty && !hold;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (!hold),
        .rd_data (head_byte),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Byte as it will appear on data_out; folding does not affect classification.
    always_comb begin
        fwd_byte = head_byte;
`ifdef CASE_FOLD_EN
        if (head_byte >= 8'h41 && head_byte <= 8'h5A) begin
            fwd_byte = head_byte + 8'h20;
        end
`endif
    end

    // Classify the popped byte, advance the framing FSM and register all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= '0;
            en       <= 1'b0;
            data_out <= '0;
            word_end <= 1'b0;
            word_len <= '0;
            word_ovf <= 1'b0;
        end else begin
            en       <= 1'b0;
            word_end <= 1'b0;
            if (pop) begin
                if (is_terminator(head_byte)) begin
                    // Terminators in S_IDLE are swallowed so CRLF / blank lines stay silent.
                    if (state != S_IDLE) begin
                        word_end <= 1'b1;
                        word_len <= count;
                        word_ovf <= (state == S_DROP);
                        count    <= '0;
                        state    <= S_IDLE;
                    end
                end else if (is_printable(head_byte)) begin
                    if (count < MaxLen) begin
                        en       <= 1'b1;
                        data_out <= fwd_byte;
                        count    <= count + 6'd1;
                        state    <= S_WORD;
                    end else begin
                        // Count saturates; excess characters only mark the overflow.
                        state <= S_DROP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_char_stream_framer.sv
// Scoreboard bench for char_stream_framer: stimulus pushes hand-computed expected
// outputs into a queue, a negedge monitor pops and compares on every en/word_end.
module tb_char_stream_framer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       hold = 1'b0;
    logic       en;
    logic [7:0] data_out;
    logic       word_end;
    logic [5:0] word_len;
    logic       word_ovf;
    logic [3:0] fifo_level;

    char_stream_framer #(
        .DEPTH   (8),
        .MAX_LEN (63)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .hold       (hold),
        .en         (en),
        .data_out   (data_out),
        .word_end   (word_end),
        .word_len   (word_len),
        .word_ovf   (word_ovf),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_end;
        logic [7:0] data;
        logic [5:0] len;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   en_cycles[$];
    int   end_cycles[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   accept_cyc = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endfunction

    function automatic void exp_char(input logic [7:0] b);
        exp_t e;
        e.is_end = 1'b0; e.data = b; e.len = '0; e.ovf = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_end(input logic [5:0] l, input logic o);
        exp_t e;
        e.is_end = 1'b1; e.data = '0; e.len = l; e.ovf = o;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every presented output against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (en || word_end) chk("en_word_end_exclusive", en & word_end, 1'b0);
            if (en) begin
                en_cycles.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_en", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("char_kind", e.is_end, 1'b0);
                    chk("char_data", data_out, e.data);
                end
            end
            if (word_end) begin
                end_cycles.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_word_end", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("end_kind", e.is_end, 1'b1);
                    chk("word_len", word_len, e.len);
                    chk("word_ovf", word_ovf, e.ovf);
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk({"drain_", name}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int first_acc;
        int n;

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_en", en, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_word_end", word_end, 1'b0);
        chk("rst_word_len", word_len, 6'd0);
        chk("rst_word_ovf", word_ovf, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: "abc\n" back-to-back, latency and consecutive en
        en_cycles.delete(); end_cycles.delete();
        exp_char(8'h61); exp_char(8'h62); exp_char(8'h63); exp_end(6'd3, 1'b0);
        push(8'h61); first_acc = accept_cyc;
        push(8'h62); push(8'h63); push(8'h0A);
        drain("t1");
        chk("t1_en_count", en_cycles.size(), 3);
        if (en_cycles.size() == 3) begin
            chk("t1_latency", en_cycles[0], first_acc + 1);
            chk("t1_consec1", en_cycles[1], en_cycles[0] + 1);
            chk("t1_consec2", en_cycles[2], en_cycles[1] + 1);
            chk("t1_end_cycle", end_cycles.size() == 1 ? end_cycles[0] : 0, en_cycles[2] + 1);
        end

        // 2: CR LF LF with no chars -> silent; next word counts from 0
        en_cycles.delete(); end_cycles.delete();
        push(8'h0D); push(8'h0A); push(8'h0A);
        repeat (4) @(negedge clk);
        chk("t2_no_en", en_cycles.size(), 0);
        chk("t2_no_end", end_cycles.size(), 0);
        exp_char(8'h7A); exp_end(6'd1, 1'b0);
        push(8'h7A); push(8'h0A);
        drain("t2");

        // 3: 70 'x' then LF -> 63 forwarded, overflow flagged
        en_cycles.delete();
        for (int i = 0; i < 63; i++) exp_char(8'h78);
        exp_end(6'd63, 1'b1);
        for (int i = 0; i < 70; i++) push(8'h78);
        push(8'h0A);
        drain("t3");
        chk("t3_en_count", en_cycles.size(), 63);

        // 4: hold=1, 9 pushes -> 8 stored, 9th stalled; release drains in order
        en_cycles.delete();
        hold = 1'b1;
        for (int i = 0; i < 9; i++) exp_char(8'h61 + 8'(i));
        exp_end(6'd9, 1'b0);
        for (int i = 0; i < 8; i++) push(8'h61 + 8'(i));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h69;
        chk("t4_full_ready", in_ready, 1'b0);
        chk("t4_full_level", fifo_level, 4'd8);
        repeat (3) @(negedge clk);
        chk("t4_still_level", fifo_level, 4'd8);
        chk("t4_no_en_held", en_cycles.size(), 0);
        hold = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ready_after_release", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        push(8'h0A);
        drain("t4");
        chk("t4_en_count", en_cycles.size(), 9);
        if (en_cycles.size() == 9)
            chk("t4_one_per_cycle", en_cycles[8] - en_cycles[0], 8);

        // 5: non-printables dropped; case handling
        exp_char(8'h6F); exp_char(8'h6B); exp_end(6'd2, 1'b0);
        push(8'h07); push(8'h6F); push(8'h7F); push(8'h80); push(8'h6B); push(8'h0A);
        drain("t5a");
`ifdef CASE_FOLD_EN
        exp_char(8'h61); exp_char(8'h62);
`else
        exp_char(8'h41); exp_char(8'h42);
`endif
        exp_end(6'd2, 1'b0);
        push(8'h41); push(8'h42); push(8'h0A);
        drain("t5b");

        // 6: async reset mid-word; only 'q' is seen before reset kills 'w'
        exp_char(8'h71);
        push(8'h71); push(8'h77); push(8'h65);
        reset = 1'b0;
        #1;
        chk("t6_en", en, 1'b0);
        chk("t6_data_out", data_out, 8'h00);
        chk("t6_word_end", word_end, 1'b0);
        chk("t6_level", fifo_level, 4'd0);
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_scoreboard", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        en_cycles.delete(); end_cycles.delete();
        repeat (3) @(negedge clk);
        chk("t6_no_end_after_reset", end_cycles.size(), 0);
        exp_char(8'h7A); exp_end(6'd1, 1'b0);
        push(8'h7A); push(8'h0A);
        drain("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
